// File: rtl/baseband_pulse_pkg.sv
// Shared state encoding and default timing constants for the baseband pulse generator.
// BB_PREAMBLE_EN adds the PREAMBLE state; the pattern defaults live here either way.
package baseband_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_GAP      = 2'd2
`ifdef BB_PREAMBLE_EN
    , ST_PREAMBLE = 2'd3
`endif
  } bb_state_t;

  localparam int BB_SYMBOL_CYCLES = 16;
  localparam int BB_PULSE_CYCLES  = 4;
  localparam int BB_GAP_SYMBOLS   = 2;

  localparam int         BB_PREAMBLE_W = 4;
  localparam logic [3:0] BB_PREAMBLE   = 4'b1010;

endpackage

// File: rtl/bb_symbol_timer.sv
// Symbol slot counter: start loads 0 and runs, clear stops at 0; flags decode the current count.
// Latency: flags are combinational on the count register; no backpressure, runs freely once started.
module bb_symbol_timer
  import baseband_pulse_pkg::*;
#(
  parameter int SYMBOL_CYCLES = BB_SYMBOL_CYCLES,
  parameter int PULSE_CYCLES  = BB_PULSE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic in_pulse,
  output logic pulse_end,
  output logic slot_end
);

  localparam int CW = $clog2(SYMBOL_CYCLES);

  logic [CW-1:0] count;
  logic          run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      run   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      run   <= 1'b0;
    end else if (start) begin
      count <= '0;
      run   <= 1'b1;
    end else if (run) begin
      count <= slot_end ? '0 : count + CW'(1);
    end
  end

  assign in_pulse  = count < CW'(PULSE_CYCLES);
  assign pulse_end = count == CW'(PULSE_CYCLES - 1);
  assign slot_end  = run && (count == CW'(SYMBOL_CYCLES - 1));

endmodule

// File: rtl/baseband_pulse_gen.sv
// Serializes a byte MSB first into per-bit pulses; first pulse one cycle after the handshake, optional BB_PREAMBLE_EN preamble.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored for the whole frame and its guard gap.
module baseband_pulse_gen
  import baseband_pulse_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SYMBOL_CYCLES = BB_SYMBOL_CYCLES,
  parameter int PULSE_CYCLES  = BB_PULSE_CYCLES,
  parameter int GAP_SYMBOLS   = BB_GAP_SYMBOLS
`ifdef BB_PREAMBLE_EN
  , parameter int PREAMBLE_W = BB_PREAMBLE_W,
  parameter logic [PREAMBLE_W-1:0] PREAMBLE = BB_PREAMBLE
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              baseband_pulse_1,
  output logic              baseband_pulse_0,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = (GAP_SYMBOLS > 1) ? $clog2(GAP_SYMBOLS) : 1;

  bb_state_t         state, state_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic [GW-1:0]     gap_cnt, gap_nxt;
  logic              tmr_start, tmr_clear;
  logic              in_pulse, pulse_end, slot_end;
  logic              tx_active_nxt, tx_bit_nxt, pulse_on_nxt;

`ifdef BB_PREAMBLE_EN
  localparam int PW = $clog2(PREAMBLE_W + 1);
  logic [PREAMBLE_W-1:0] pre_sreg, pre_nxt;
  logic [PW-1:0]         pre_cnt, pre_cnt_nxt;
`endif

  bb_symbol_timer #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start),
    .clear    (tmr_clear),
    .in_pulse (in_pulse),
    .pulse_end(pulse_end),
    .slot_end (slot_end)
  );

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bit_nxt   = bit_cnt;
    gap_nxt   = gap_cnt;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
`ifdef BB_PREAMBLE_EN
    pre_nxt     = pre_sreg;
    pre_cnt_nxt = pre_cnt;
`endif
    case (state)
      ST_IDLE: begin
        // in_ready is registered high for every IDLE cycle, so in_valid alone completes the handshake
        if (in_valid) begin
          sreg_nxt  = in_data;
          bit_nxt   = '0;
          gap_nxt   = '0;
          tmr_start = 1'b1;
`ifdef BB_PREAMBLE_EN
          pre_nxt     = PREAMBLE;
          pre_cnt_nxt = '0;
          state_nxt   = ST_PREAMBLE;
`else
          state_nxt = ST_SEND;
`endif
        end
      end
`ifdef BB_PREAMBLE_EN
      ST_PREAMBLE: begin
        if (slot_end) begin
          pre_nxt     = pre_sreg << 1;
          pre_cnt_nxt = pre_cnt + PW'(1);
          if (pre_cnt == PW'(PREAMBLE_W - 1)) state_nxt = ST_SEND;
        end
      end
`endif
      ST_SEND: begin
        if (slot_end) begin
          sreg_nxt = sreg << 1;
          bit_nxt  = bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_W - 1)) begin
            if (GAP_SYMBOLS == 0) begin
              state_nxt = ST_IDLE;
              tmr_clear = 1'b1;
            end else begin
              state_nxt = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (slot_end) begin
          if (gap_cnt == GW'(GAP_SYMBOLS - 1)) begin
            state_nxt = ST_IDLE;
            tmr_clear = 1'b1;
          end else begin
            gap_nxt = gap_cnt + GW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tmr_clear = 1'b1;
      end
    endcase

`ifdef BB_PREAMBLE_EN
    tx_active_nxt = (state_nxt == ST_SEND) || (state_nxt == ST_PREAMBLE);
    tx_bit_nxt    = (state_nxt == ST_PREAMBLE) ? pre_nxt[PREAMBLE_W-1] : sreg_nxt[DATA_W-1];
`else
    tx_active_nxt = (state_nxt == ST_SEND);
    tx_bit_nxt    = sreg_nxt[DATA_W-1];
`endif
    // Look one cycle ahead so the pulse registers line up with count 0 of each slot
    pulse_on_nxt = tx_active_nxt && (tmr_start || slot_end || (in_pulse && !pulse_end));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      sreg             <= '0;
      bit_cnt          <= '0;
      gap_cnt          <= '0;
      in_ready         <= 1'b1;
      baseband_pulse_1 <= 1'b0;
      baseband_pulse_0 <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      state            <= state_nxt;
      sreg             <= sreg_nxt;
      bit_cnt          <= bit_nxt;
      gap_cnt          <= gap_nxt;
      in_ready         <= (state_nxt == ST_IDLE);
      baseband_pulse_1 <= pulse_on_nxt && tx_bit_nxt;
      baseband_pulse_0 <= pulse_on_nxt && !tx_bit_nxt;
      busy             <= (state_nxt != ST_IDLE);
      frame_done       <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
    end
  end

`ifdef BB_PREAMBLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_sreg <= '0;
      pre_cnt  <= '0;
    end else begin
      pre_sreg <= pre_nxt;
      pre_cnt  <= pre_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_baseband_pulse_gen.sv
// Directed bench for baseband_pulse_gen: default build plus a fast SYMBOL_CYCLES=2 instance.
// Outputs are sampled 1 time unit after each rising edge; cycle k counts edges after the handshake.
module tb_baseband_pulse_gen;

`ifdef BB_PREAMBLE_EN
  localparam int PRE_W = 4;
`else
  localparam int PRE_W = 0;
`endif
  localparam int SYM = 16;
  localparam int PUL = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, baseband_pulse_1, baseband_pulse_0, busy, frame_done;
  logic [7:0] s_in_data;
  logic       s_in_valid;
  logic       s_in_ready, s_p1, s_p0, s_busy, s_fd;

  int checks   = 0;
  int failures = 0;
  int both_hi;
  int fd_at;
  logic [255:0] tr1, tr0, m1, m0;

  always #5 clk = ~clk;

  baseband_pulse_gen #(
    .DATA_W(8), .SYMBOL_CYCLES(SYM), .PULSE_CYCLES(PUL), .GAP_SYMBOLS(GAP)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .baseband_pulse_1(baseband_pulse_1), .baseband_pulse_0(baseband_pulse_0),
    .busy(busy), .frame_done(frame_done)
  );

  baseband_pulse_gen #(
    .DATA_W(8), .SYMBOL_CYCLES(2), .PULSE_CYCLES(1), .GAP_SYMBOLS(0)
  ) dut_s (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .baseband_pulse_1(s_p1), .baseband_pulse_0(s_p0), .busy(s_busy), .frame_done(s_fd)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {in_ready, frame_done, busy, pulse_1, pulse_0} at cycle k after the handshake
  function automatic logic [4:0] exp_vec(input logic [7:0] b, input int k, input int sym,
                                         input int pul, input int gap);
    int         len, t, slot, pos;
    logic       bitv;
    logic [3:0] pre_bits;
    pre_bits = 4'b1010;
    len = (PRE_W + 8 + gap) * sym;
    if (k == len + 1) return 5'b11000;
    t    = k - 1;
    slot = t / sym;
    pos  = t % sym;
    if (slot < PRE_W + 8 && pos < pul) begin
      bitv = (slot < PRE_W) ? pre_bits[PRE_W-1-slot] : b[7-(slot-PRE_W)];
      return {3'b001, bitv, ~bitv};
    end
    return 5'b00100;
  endfunction

  // Entered in the handshake cycle; leaves in the in_ready cycle that ends the frame
  task automatic frame(input logic [7:0] b, input logic [7:0] next_b, input bit chain, input bit hold);
    int         len;
    logic [4:0] v;
    len = (PRE_W + 8 + GAP) * SYM;
    in_data  = b;
    in_valid = 1'b1;
    chk($sformatf("hs_ready_%h", b), in_ready, 1);
    tr1 = '0; tr0 = '0; both_hi = 0; fd_at = -1;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    for (int k = 1; k <= len + 1; k++) begin
      v = {in_ready, frame_done, busy, baseband_pulse_1, baseband_pulse_0};
      tr1[k] = v[1];
      tr0[k] = v[0];
      if (v[1] && v[0]) both_hi++;
      if (v[3] && fd_at < 0) fd_at = k;
      chk($sformatf("frame_%h_cyc%0d", b, k), v, exp_vec(b, k, SYM, PUL, GAP));
      if (hold) in_data = 8'($urandom);
      if (k == len + 1) begin
        in_valid = chain;
        if (chain) in_data = next_b;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int s1[4];
    int s0[4];
    int a_off, s_off, sl;
    logic [4:0] v;
    s1 = '{1, 33, 81, 113};
    s0 = '{17, 49, 65, 97};
    a_off = PRE_W * SYM;
    s_off = PRE_W * 2;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; s_in_valid = 1'b0; s_in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, frame_done, busy, baseband_pulse_1, baseband_pulse_0}, 5'b10000);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_%0d", i), {in_ready, frame_done, busy, baseband_pulse_1, baseband_pulse_0}, 5'b10000);
    end

    // 0xA5 against hand-listed pulse windows
    frame(8'hA5, 8'h00, 1'b0, 1'b0);
    m1 = '0; m0 = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        m1[s1[i] + a_off + j] = 1'b1;
        m0[s0[i] + a_off + j] = 1'b1;
      end
    if (PRE_W > 0)
      for (int j = 0; j < 4; j++) begin
        m1[1 + j] = 1'b1; m1[33 + j] = 1'b1;
        m0[17 + j] = 1'b1; m0[49 + j] = 1'b1;
      end
    chk("a5_pulse1_trace", tr1, m1);
    chk("a5_pulse0_trace", tr0, m0);
    chk("a5_done_cycle", fd_at, 161 + a_off);
    @(posedge clk); #1;
    chk("done_one_cycle", {in_ready, frame_done, busy, baseband_pulse_1, baseband_pulse_0}, 5'b10000);

    // Back-to-back 0xFF then 0x00, second handshake on the in_ready cycle
    frame(8'hFF, 8'h00, 1'b1, 1'b0);
    chk("ff_both_high", both_hi, 0);
    chk("ff_pulse1_cycles", $countones(tr1), 32 + (PRE_W / 2) * PUL);
    frame(8'h00, 8'h00, 1'b0, 1'b0);
    chk("00_both_high", both_hi, 0);
    chk("00_pulse0_cycles", $countones(tr0), 32 + (PRE_W / 2) * PUL);
    @(posedge clk); #1;

    // in_valid held with changing data: only the latched byte goes out, 0xC3 taken at in_ready
    frame(8'h5A, 8'hC3, 1'b1, 1'b1);
    frame(8'hC3, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a pulse
    in_data = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    chk("pre_reset_pulse1", baseband_pulse_1, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {in_ready, frame_done, busy, baseband_pulse_1, baseband_pulse_0}, 5'b10000);
    in_data = 8'h99; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("no_hs_in_reset", {in_ready, frame_done, busy, baseband_pulse_1, baseband_pulse_0}, 5'b10000);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_idle", {in_ready, frame_done, busy, baseband_pulse_1, baseband_pulse_0}, 5'b10000);
    frame(8'h3C, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Fast instance: 2-cycle slots, 1-cycle pulses, no gap, byte 0x80
    sl = (PRE_W + 8) * 2;
    chk("small_ready", s_in_ready, 1);
    s_in_data = 8'h80; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    tr1 = '0; tr0 = '0; fd_at = -1;
    for (int k = 1; k <= sl + 1; k++) begin
      v = {s_in_ready, s_fd, s_busy, s_p1, s_p0};
      tr1[k] = v[1];
      tr0[k] = v[0];
      if (v[3] && fd_at < 0) fd_at = k;
      chk($sformatf("small_cyc%0d", k), v, exp_vec(8'h80, k, 2, 1, 0));
      if (k != sl + 1) begin
        @(posedge clk); #1;
      end
    end
    m1 = '0; m0 = '0;
    m1[1 + s_off] = 1'b1;
    for (int c = 3; c <= 15; c += 2) m0[c + s_off] = 1'b1;
    if (PRE_W > 0) begin
      m1[1] = 1'b1; m1[5] = 1'b1;
      m0[3] = 1'b1; m0[7] = 1'b1;
    end
    chk("small_pulse1_trace", tr1, m1);
    chk("small_pulse0_trace", tr0, m0);
    chk("small_done_cycle", fd_at, 17 + s_off);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
